// File: rtl/if_prefetch_pkg.sv
// Shared processor definitions for the fetch front end: word width,
// default reset PC and the {instr, npc} entry carried through the prefetch queue.
package if_prefetch_pkg;

    localparam int XLEN = 8;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 8'h00;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t npc;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_fetch_fifo.sv
// Small synchronous FIFO of {instr, npc} entries with synchronous clear.
// Clear wins over push and pop in the same cycle.
module fetch_fifo
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   slots [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push && !clear) slots[wr_ptr] <= push_data;
    end

    assign head = slots[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch front end: issues reads from its own fetch PC, queues the
// returned bytes with their NPC and hands them to IF/ID over valid/ready.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [7:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PC_sel,
    input  logic [7:0] Target,
    output logic       imem_en,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [7:0] Instr,
    output logic [7:0] NPC,
    output logic       valid,
    input  logic       ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    word_t              fpc;
    word_t              req_addr;
    logic               inflight;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     pending;
    logic               room;
    logic               pop;
    logic               push;
    fetch_entry_t       push_data;
    fetch_entry_t       head;

    assign valid = (count != '0);
    assign pop   = valid & ready;

    // A response is already owed a slot, so it counts against the space left.
    assign pending = (CNT_W + 1)'(count) + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
    assign room    = pending < (CNT_W + 1)'(DEPTH);

    always_comb begin
        imem_en   = 1'b0;
        imem_addr = fpc;
        if (reset) begin
            if (PC_sel) begin
                imem_en   = 1'b1;
                imem_addr = Target;
            end else if (room) begin
                imem_en   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc      <= RESET_PC;
            req_addr <= RESET_PC;
            inflight <= 1'b0;
        end else if (PC_sel) begin
            fpc      <= Target + 8'd1;
            req_addr <= Target;
            inflight <= 1'b1;
        end else if (imem_en) begin
            fpc      <= fpc + 8'd1;
            req_addr <= fpc;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    // The response landing during a redirect belongs to the old stream.
    assign push            = inflight & ~PC_sel;
    assign push_data.instr = imem_data;
    assign push_data.npc   = req_addr + 8'd1;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (PC_sel),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign Instr = valid ? head.instr : 8'h00;
    assign NPC   = valid ? head.npc   : 8'h00;

endmodule
